boss_bomb_ctrl: RTL
===================

Name: boss_bomb_ctrl

Overview:
- Responder end of the boss `shoot`/`NoBomb` handshake. The boss pulses `shoot`, then waits in its bomb state until `NoBomb` is high.
- This block launches a fan of NUM_BOMBS red bombs from the boss position and flies them under gravity each frame.
- It retires bombs on ground, edge or kid contact, and reports `NoBomb` once the volley is finished.
- It also drives per-pixel `isBomb` and `Bomb_address` to the colour mapper and a `hitKid` pulse to the kid logic.

Parameters:
- NUM_BOMBS, 4, bombs per volley (1..8).
- SPRITE_BASE, 25'd70000, sprite ROM address of the 16x16 bomb image.
- LAUNCH_VY, -12, initial vertical velocity (10-bit two's complement, upward).
- VY_MAX, 15, terminal downward velocity.
- GROUND_Y, 448, a bomb centre at y >= GROUND_Y retires.
- COOLDOWN, 20, frames held after the last bomb retires before `NoBomb` rises.
- MAX_FLY_FRAMES, 120, timeout length (optional feature only).

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- shoot  in  1  volley request from boss, one frame wide.
- Boss_dead  in  1  synchronous clear: retire all bombs, go to IDLE.
- Boss_position_X, Boss_position_Y  in  10 each  boss centre.
- Kid_position_X, Kid_position_Y  in  10 each  kid top-left; kid box is 32x32.
- DrawX, DrawY  in  10 each  current VGA pixel.
- NoBomb  out  1  high only in IDLE.
- hitKid  out  1  registered, one frame wide.
- isBomb  out  1  combinational; current pixel lies on an active bomb.
- Bomb_address  out  25  sprite ROM address; 0 when `isBomb` is 0.

Behaviour:
- Reset: state IDLE, all slots inactive, all positions and velocities 0, `hitKid` 0, `NoBomb` 1, `isBomb` 0, `Bomb_address` 0.
- FSM states: IDLE, FLY, COOLDOWN_S.
- `NoBomb` is decoded combinationally from state, so it is 0 on the same edge the boss enters its wait state. This makes a false early release impossible.
- IDLE: if `shoot` is 1 and `Boss_dead` is 0, load all slots on that edge and go to FLY.
  - Slot i gets x = Boss_position_X, y = Boss_position_Y - 32, vy = LAUNCH_VY, active = 1.
  - Slot i gets vx = dir*(2+2i), where dir = -1 if Kid_position_X + 16 < Boss_position_X, else +1.
- `shoot` outside IDLE is ignored; there is no queueing.
- FLY, per active slot per frame:
  - x += vx, y += vy (10-bit wrap arithmetic, signed compare).
  - vy += 1, saturating at VY_MAX.
  - The retire check uses the pre-update position, so a spawned bomb is always visible for at least one frame.
- Retire conditions, evaluated in priority order:
  1. Kid hit: Kid_X <= x <= Kid_X+31 and Kid_Y <= y <= Kid_Y+31. Sets `hitKid` = 1 next frame.
  2. y >= GROUND_Y.
  3. x < 8 or x > 631.
- Several bombs hitting the kid in one frame still produce a single `hitKid` pulse.
- When all slots are inactive, go to COOLDOWN_S and load a counter with COOLDOWN-1.
- COOLDOWN_S: decrement the counter each frame; at 0 go to IDLE. A `shoot` during cooldown is ignored.
- `Boss_dead` = 1 in any state: next edge all slots inactive, state IDLE, `hitKid` 0. It takes priority over `shoot`.
- Draw path:
  - dx = DrawX - x + 8, dy = DrawY - y + 8, both in 0..15.
  - `isBomb` = 1 and `Bomb_address` = SPRITE_BASE + dy*16 + dx.
  - When bombs overlap, the lowest-index active slot wins.
- Asserting Reset_n low mid-volley clears immediately and asynchronously to the reset values above.

Optional Feature:
- BOMB_TIMEOUT_EN defined: a frame counter starts on entry to FLY. After MAX_FLY_FRAMES frames in FLY, all slots are forced inactive and the FSM enters COOLDOWN_S. This guards against a bomb stuck off-path.
- Not defined: no counter; FLY ends only by retirement or `Boss_dead`.

Decomposition:
- Package boss_bomb_pkg:
  - state enum bomb_state_t {IDLE, FLY, COOLDOWN_S}.
  - bomb_slot_t struct {active, x, y, vx, vy}.
  - Constants for kid size 32 and sprite size 16.
- Sub-module bomb_slot, instantiated NUM_BOMBS times:
  - Holds one slot's registers, load, motion, gravity and the retire compare.
  - Outputs active, kid-hit and draw-hit with local address.
- Top level owns the FSM, cooldown/timeout counters, the `hitKid` OR and the draw priority mux.

Test Plan:
- Reset -> `NoBomb`=1, `isBomb`=0, `Bomb_address`=0, `hitKid`=0.
- Boss (607,416), kid (100,416), one-frame `shoot`:
  - Next edge `NoBomb`=0; slots at (607,384) with vx -2,-4,-6,-8.
  - After one FLY frame, slot0 is at (605,372) with vy=-11.
- Let the volley land:
  - Every bomb retires at y >= 448.
  - `NoBomb` stays 0 for exactly 20 further frames, then goes to 1.
  - `shoot` during cooldown has no effect.
- Kid placed on slot1's path -> `hitKid` is 1 for exactly one frame, slot1 vanishes, the other bombs continue.
- `Boss_dead` asserted mid-FLY -> next edge `isBomb`=0 everywhere and `NoBomb`=1. `shoot` in the same frame is ignored.
- Draw check:
  - DrawX=605, DrawY=372 with slot0 at (605,372) -> `isBomb`=1, `Bomb_address`=70000+8*16+8=70136.
  - DrawX=614 -> `isBomb`=0.

Source files
------------

// File: rtl/boss_bomb_pkg.sv
// rtl/boss_bomb_pkg.sv - shared types and constants for the boss bomb volley
package boss_bomb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLY        = 2'd1,
    COOLDOWN_S = 2'd2
  } bomb_state_t;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] vx;
    logic [9:0] vy;
  } bomb_slot_t;

  localparam int         KID_SIZE     = 32;
  localparam logic [9:0] SPRITE_SIZE  = 10'd16;
  localparam logic [9:0] SPRITE_HALF  = 10'd8;
  localparam logic [9:0] LAUNCH_Y_OFS = 10'd32;
  localparam logic [9:0] EDGE_MIN_X   = 10'd8;
  localparam logic [9:0] EDGE_MAX_X   = 10'd631;

  // One frame of gravity: speed up by one, never beyond terminal velocity
  function automatic logic [9:0] gravity_step(input logic [9:0] vy, input logic [9:0] vy_max);
    if ($signed(vy) >= $signed(vy_max)) begin
      return vy_max;
    end
    return vy + 10'd1;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb: launch, motion, gravity, retire test and sprite hit
module bomb_slot #(
  parameter int SLOT_IDX  = 0,
  parameter int LAUNCH_VY = -12,
  parameter int VY_MAX    = 15,
  parameter int GROUND_Y  = 448
) (
  input  logic       frame_clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       step,
  input  logic       dir_left,
  input  logic [9:0] boss_x,
  input  logic [9:0] boss_y,
  input  logic [9:0] kid_x,
  input  logic [9:0] kid_y,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       active,
  output logic       retire,
  output logic       kid_hit,
  output logic       draw_hit,
  output logic [7:0] draw_offset
);
  import boss_bomb_pkg::*;

  localparam logic [9:0]        SPEED     = 10'(2 + 2 * SLOT_IDX);
  localparam logic [9:0]        VY_LAUNCH = 10'(LAUNCH_VY);
  localparam logic [9:0]        VY_TOP    = 10'(VY_MAX);
  localparam logic signed [9:0] GROUND_S  = 10'(GROUND_Y);
  localparam logic [10:0]       KID_SPAN  = 11'(KID_SIZE - 1);

  bomb_slot_t slot_q, slot_d;
  logic       in_kid_box, on_ground, off_edge;
  logic [9:0] dx, dy;

  assign active = slot_q.active;

  // Retire test on the current (pre-move) position; y is signed so a bomb
  // flung above the top of the screen is not mistaken for a landed one
  always_comb begin
    in_kid_box = ({1'b0, slot_q.x} >= {1'b0, kid_x}) &&
                 ({1'b0, slot_q.x} <= {1'b0, kid_x} + KID_SPAN) &&
                 ({1'b0, slot_q.y} >= {1'b0, kid_y}) &&
                 ({1'b0, slot_q.y} <= {1'b0, kid_y} + KID_SPAN);
    on_ground  = $signed(slot_q.y) >= GROUND_S;
    off_edge   = (slot_q.x < EDGE_MIN_X) || (slot_q.x > EDGE_MAX_X);
    kid_hit    = slot_q.active && in_kid_box;
    retire     = slot_q.active && (in_kid_box || on_ground || off_edge);
  end

  // Next slot state: clear beats launch, launch beats flight
  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d.active = 1'b0;
    end else if (load) begin
      slot_d.active = 1'b1;
      slot_d.x      = boss_x;
      slot_d.y      = boss_y - LAUNCH_Y_OFS;
      slot_d.vx     = dir_left ? -SPEED : SPEED;
      slot_d.vy     = VY_LAUNCH;
    end else if (step && slot_q.active) begin
      if (retire) begin
        slot_d.active = 1'b0;
      end else begin
        slot_d.x  = slot_q.x + slot_q.vx;
        slot_d.y  = slot_q.y + slot_q.vy;
        slot_d.vy = gravity_step(slot_q.vy, VY_TOP);
      end
    end
  end

  // Slot register
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Sprite-local coordinates of the current pixel; outside 0..15 wraps high
  always_comb begin
    dx          = draw_x - slot_q.x + SPRITE_HALF;
    dy          = draw_y - slot_q.y + SPRITE_HALF;
    draw_hit    = slot_q.active && (dx < SPRITE_SIZE) && (dy < SPRITE_SIZE);
    draw_offset = {dy[3:0], dx[3:0]};
  end

endmodule

// File: rtl/boss_bomb_ctrl.sv
// rtl/boss_bomb_ctrl.sv - boss bomb volley controller; define BOMB_TIMEOUT_EN for the FLY timeout
module boss_bomb_ctrl #(
  parameter int          NUM_BOMBS      = 4,
  parameter logic [24:0] SPRITE_BASE    = 25'd70000,
  parameter int          LAUNCH_VY      = -12,
  parameter int          VY_MAX         = 15,
  parameter int          GROUND_Y       = 448,
  parameter int          COOLDOWN       = 20
`ifdef BOMB_TIMEOUT_EN
  ,
  parameter int          MAX_FLY_FRAMES = 120
`endif
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        shoot,
  input  logic        Boss_dead,
  input  logic [9:0]  Boss_position_X,
  input  logic [9:0]  Boss_position_Y,
  input  logic [9:0]  Kid_position_X,
  input  logic [9:0]  Kid_position_Y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        NoBomb,
  output logic        hitKid,
  output logic        isBomb,
  output logic [24:0] Bomb_address
);
  import boss_bomb_pkg::*;

  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN - 1);

  bomb_state_t          state_q, state_d;
  logic [7:0]           cool_cnt_q, cool_cnt_d;
  logic                 hit_kid_q, hit_kid_d;
  logic                 launch, timeout, dir_left, slot_clear;
  logic [NUM_BOMBS-1:0] slot_active, slot_retire, slot_kid, slot_draw;
  logic [7:0]           slot_off [NUM_BOMBS];

  assign launch     = (state_q == IDLE) && shoot && !Boss_dead;
  assign dir_left   = ({1'b0, Kid_position_X} + 11'(KID_SIZE / 2)) < {1'b0, Boss_position_X};
  assign slot_clear = Boss_dead || timeout;
  assign NoBomb     = (state_q == IDLE);
  assign hitKid     = hit_kid_q;

  for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
    bomb_slot #(
      .SLOT_IDX  (i),
      .LAUNCH_VY (LAUNCH_VY),
      .VY_MAX    (VY_MAX),
      .GROUND_Y  (GROUND_Y)
    ) u_slot (
      .frame_clk   (frame_clk),
      .rst_n       (Reset_n),
      .clear       (slot_clear),
      .load        (launch),
      .step        (state_q == FLY),
      .dir_left    (dir_left),
      .boss_x      (Boss_position_X),
      .boss_y      (Boss_position_Y),
      .kid_x       (Kid_position_X),
      .kid_y       (Kid_position_Y),
      .draw_x      (DrawX),
      .draw_y      (DrawY),
      .active      (slot_active[i]),
      .retire      (slot_retire[i]),
      .kid_hit     (slot_kid[i]),
      .draw_hit    (slot_draw[i]),
      .draw_offset (slot_off[i])
    );
  end

`ifdef BOMB_TIMEOUT_EN
  logic [7:0] fly_cnt_q, fly_cnt_d;

  // Count frames spent in FLY so a volley stuck off-path is abandoned
  always_comb begin
    fly_cnt_d = fly_cnt_q;
    timeout   = 1'b0;
    if (launch) begin
      fly_cnt_d = '0;
    end else if (state_q == FLY) begin
      if (fly_cnt_q == 8'(MAX_FLY_FRAMES - 1)) begin
        timeout = 1'b1;
      end else begin
        fly_cnt_d = fly_cnt_q + 8'd1;
      end
    end
  end

  // Flight-time counter register
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fly_cnt_q <= '0;
    end else begin
      fly_cnt_q <= fly_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Volley sequencing; the cooldown is armed on the edge the last bomb retires
  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    hit_kid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = FLY;
        end
      end
      FLY: begin
        hit_kid_d = |slot_kid;
        if (timeout || !(|(slot_active & ~slot_retire))) begin
          state_d    = COOLDOWN_S;
          cool_cnt_d = COOL_INIT;
        end
      end
      COOLDOWN_S: begin
        if (cool_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Boss_dead) begin
      state_d   = IDLE;
      hit_kid_d = 1'b0;
    end
  end

  // FSM, cooldown and hit-pulse registers
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cool_cnt_q <= '0;
      hit_kid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      hit_kid_q  <= hit_kid_d;
    end
  end

  // Draw mux: scan from the top so the lowest-index active bomb wins
  always_comb begin
    isBomb       = 1'b0;
    Bomb_address = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (slot_draw[i]) begin
        isBomb       = 1'b1;
        Bomb_address = SPRITE_BASE + 25'(slot_off[i]);
      end
    end
  end

endmodule
